// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// Each port owns a one-deep response slot; round-robin or fixed-priority grant.
module alu_arbiter #(
   parameter int XLEN        = 32,
   parameter int ROUND_ROBIN = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [3:0]      req0_opcode_i,
   input  logic [XLEN-1:0] req0_op1_i,
   input  logic [XLEN-1:0] req0_op2_i,
   output logic            rsp0_valid_o,
   input  logic            rsp0_ready_i,
   output logic [XLEN-1:0] rsp0_data_o,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [3:0]      req1_opcode_i,
   input  logic [XLEN-1:0] req1_op1_i,
   input  logic [XLEN-1:0] req1_op2_i,
   output logic            rsp1_valid_o,
   input  logic            rsp1_ready_i,
   output logic [XLEN-1:0] rsp1_data_o,
   output logic [3:0]      alu_opcode_o,
   output logic [XLEN-1:0] alu_op1_o,
   output logic [XLEN-1:0] alu_op2_o,
   input  logic [XLEN-1:0] alu_res_i
);

   localparam bit RR = (ROUND_ROBIN != 0);

   logic            rsp0_valid_q, rsp0_valid_d;
   logic            rsp1_valid_q, rsp1_valid_d;
   logic [XLEN-1:0] rsp0_data_q, rsp0_data_d;
   logic [XLEN-1:0] rsp1_data_q, rsp1_data_d;
   logic            ptr_q, ptr_d;
   logic            elig0, elig1, gnt0, gnt1;

   always_comb begin
      elig0 = req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
      elig1 = req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      // On a tie the pointer names the last winner, so the other port goes next.
      if (elig0 && elig1) begin
         if (RR) begin
            gnt0 = ptr_q;
            gnt1 = !ptr_q;
         end else begin
            gnt0 = 1'b1;
         end
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
   end

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   always_comb begin
      alu_opcode_o = '0;
      alu_op1_o    = '0;
      alu_op2_o    = '0;
      if (gnt0) begin
         alu_opcode_o = req0_opcode_i;
         alu_op1_o    = req0_op1_i;
         alu_op2_o    = req0_op2_i;
      end else if (gnt1) begin
         alu_opcode_o = req1_opcode_i;
         alu_op1_o    = req1_op1_i;
         alu_op2_o    = req1_op2_i;
      end
   end

   always_comb begin
      rsp0_valid_d = rsp0_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_data_d  = rsp1_data_q;
      ptr_d        = ptr_q;
      // A new accept wins over a drain so a port can stream one op per cycle.
      if (gnt0) begin
         rsp0_valid_d = 1'b1;
         rsp0_data_d  = alu_res_i;
         ptr_d        = 1'b0;
      end else if (rsp0_valid_q && rsp0_ready_i) begin
         rsp0_valid_d = 1'b0;
      end
      if (gnt1) begin
         rsp1_valid_d = 1'b1;
         rsp1_data_d  = alu_res_i;
         ptr_d        = 1'b1;
      end else if (rsp1_valid_q && rsp1_ready_i) begin
         rsp1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
         ptr_q        <= 1'b1;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
         ptr_q        <= ptr_d;
      end
   end

   assign rsp0_valid_o = rsp0_valid_q;
   assign rsp1_valid_o = rsp1_valid_q;
   assign rsp0_data_o  = rsp0_data_q;
   assign rsp1_data_o  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: round-robin (dut_a) and fixed-priority (dut_b) arbiters share stimulus.
module tb_alu_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
   logic [3:0]  req0_opcode, req1_opcode;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;

   logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
   logic [31:0] a_rsp0_data, a_rsp1_data, a_op1, a_op2, a_res;
   logic [3:0]  a_opc;
   logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
   logic [31:0] b_rsp0_data, b_rsp1_data, b_op1, b_op2, b_res;
   logic [3:0]  b_opc;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: alu = a + b;
         4'd1: alu = a - b;
         4'd2: alu = a ^ b;
         4'd3: alu = a | b;
         4'd4: alu = a & b;
         4'd5: alu = a << b[4:0];
         4'd6: alu = a >> b[4:0];
         4'd7: alu = $unsigned($signed(a) >>> b[4:0]);
         4'd8: alu = {31'd0, $signed(a) < $signed(b)};
         4'd9: alu = {31'd0, a < b};
         default: alu = 32'd0;
      endcase
   endfunction

   assign a_res = alu(a_opc, a_op1, a_op2);
   assign b_res = alu(b_opc, b_op1, b_op2);

   alu_arbiter #(.XLEN(32), .ROUND_ROBIN(1)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid), .req0_ready_o(a_req0_ready), .req0_opcode_i(req0_opcode),
      .req0_op1_i(req0_op1), .req0_op2_i(req0_op2),
      .rsp0_valid_o(a_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(a_rsp0_data),
      .req1_valid_i(req1_valid), .req1_ready_o(a_req1_ready), .req1_opcode_i(req1_opcode),
      .req1_op1_i(req1_op1), .req1_op2_i(req1_op2),
      .rsp1_valid_o(a_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(a_rsp1_data),
      .alu_opcode_o(a_opc), .alu_op1_o(a_op1), .alu_op2_o(a_op2), .alu_res_i(a_res)
   );

   alu_arbiter #(.XLEN(32), .ROUND_ROBIN(0)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid), .req0_ready_o(b_req0_ready), .req0_opcode_i(req0_opcode),
      .req0_op1_i(req0_op1), .req0_op2_i(req0_op2),
      .rsp0_valid_o(b_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(b_rsp0_data),
      .req1_valid_i(req1_valid), .req1_ready_o(b_req1_ready), .req1_opcode_i(req1_opcode),
      .req1_op1_i(req1_op1), .req1_op2_i(req1_op2),
      .rsp1_valid_o(b_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(b_rsp1_data),
      .alu_opcode_o(b_opc), .alu_op1_o(b_op1), .alu_op2_o(b_op2), .alu_res_i(b_res)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every response handshake pops the oldest expected value.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (a_rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
            else chk("rsp0_data", a_rsp0_data, q0.pop_front());
         end
         if (a_rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
            else chk("rsp1_data", a_rsp1_data, q1.pop_front());
         end
      end
   end

   // ga/gb: expected grant for dut_a/dut_b (0 none, 1 port0, 2 port1).
   task automatic cyc(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] e0,
                      input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [31:0] e1,
                      input logic r0, input logic r1, input int ga, input int gb);
      logic [3:0]  eo;
      logic [31:0] ea, eb;
      req0_valid = v0; req0_opcode = o0; req0_op1 = a0; req0_op2 = b0;
      req1_valid = v1; req1_opcode = o1; req1_op1 = a1; req1_op2 = b1;
      rsp0_ready = r0; rsp1_ready = r1;
      @(negedge clk_i);
      chk("a_req0_ready", {31'd0, a_req0_ready}, {31'd0, ga == 1});
      chk("a_req1_ready", {31'd0, a_req1_ready}, {31'd0, ga == 2});
      chk("b_req0_ready", {31'd0, b_req0_ready}, {31'd0, gb == 1});
      chk("b_req1_ready", {31'd0, b_req1_ready}, {31'd0, gb == 2});
      eo = (ga == 1) ? o0 : (ga == 2) ? o1 : 4'd0;
      ea = (ga == 1) ? a0 : (ga == 2) ? a1 : 32'd0;
      eb = (ga == 1) ? b0 : (ga == 2) ? b1 : 32'd0;
      chk("a_alu_opcode", {28'd0, a_opc}, {28'd0, eo});
      chk("a_alu_op1", a_op1, ea);
      chk("a_alu_op2", a_op2, eb);
      if (!rst_i && ga == 1) q0.push_back(e0);
      if (!rst_i && ga == 2) q1.push_back(e1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic r0, input logic r1, input int ga, input int gb);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, r0, r1, ga, gb);
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_a_v0"}, {31'd0, a_rsp0_valid}, 32'd0);
      chk({tag, "_a_v1"}, {31'd0, a_rsp1_valid}, 32'd0);
      chk({tag, "_a_d0"}, a_rsp0_data, 32'd0);
      chk({tag, "_a_d1"}, a_rsp1_data, 32'd0);
      chk({tag, "_b_v0"}, {31'd0, b_rsp0_valid}, 32'd0);
      chk({tag, "_b_v1"}, {31'd0, b_rsp1_valid}, 32'd0);
      chk({tag, "_b_d0"}, b_rsp0_data, 32'd0);
      chk({tag, "_b_d1"}, b_rsp1_data, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      req0_valid = 1'b0; req0_opcode = '0; req0_op1 = '0; req0_op2 = '0;
      req1_valid = 1'b0; req1_opcode = '0; req1_op1 = '0; req1_op2 = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_clear("reset");
      @(posedge clk_i);
      #1;

      // Single ADD on port 0
      cyc(1, 4'd0, 32'd5, 32'd7, 32'd12, 0, 4'd0, 0, 0, 0, 1, 1, 1, 1);
      // Both valid: RR alternates, fixed priority always picks port 0
      cyc(1, 4'd1, 32'd10, 32'd3, 32'd7, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 2, 1);
      cyc(1, 4'd1, 32'd10, 32'd3, 32'd7, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 1, 1);
      cyc(1, 4'd1, 32'd10, 32'd3, 32'd7, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 2, 1);
      cyc(1, 4'd1, 32'd10, 32'd3, 32'd7, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 1, 1);
      chk("b_rsp0_data_sub", b_rsp0_data, 32'd7);
      cyc(0, 4'd0, 0, 0, 0, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 2, 2);
      idle(1, 1, 0, 0);

      // Backpressure on port 1 then drain+accept in the same cycle
      cyc(0, 4'd0, 0, 0, 0, 1, 4'd7, 32'h8000_0000, 32'd0, 32'h8000_0000, 1, 0, 2, 2);
      cyc(0, 4'd0, 0, 0, 0, 1, 4'd0, 32'd1, 32'd2, 32'd3, 1, 0, 0, 0);
      chk("held_valid", {31'd0, a_rsp1_valid}, 32'd1);
      chk("held_data", a_rsp1_data, 32'h8000_0000);
      cyc(0, 4'd0, 0, 0, 0, 1, 4'd0, 32'd1, 32'd2, 32'd3, 1, 1, 2, 2);
      chk("refill_valid", {31'd0, a_rsp1_valid}, 32'd1);
      idle(1, 1, 0, 0);

      // Undefined opcode yields zero with a normal handshake
      cyc(1, 4'd12, 32'd5, 32'd6, 32'd0, 0, 4'd0, 0, 0, 0, 1, 1, 1, 1);
      chk("op12_valid", {31'd0, a_rsp0_valid}, 32'd1);
      idle(1, 1, 0, 0);

      // Fill both slots, then reset with a grant in flight
      cyc(1, 4'd0, 32'd1, 32'd1, 32'd2, 1, 4'd0, 32'd2, 32'd2, 32'd4, 0, 0, 2, 1);
      cyc(1, 4'd0, 32'd1, 32'd1, 32'd2, 1, 4'd0, 32'd2, 32'd2, 32'd4, 0, 0, 1, 2);
      rst_i = 1'b1;
      cyc(1, 4'd0, 32'd1, 32'd1, 32'd2, 1, 4'd0, 32'd2, 32'd2, 32'd4, 1, 0, 1, 1);
      rst_i = 1'b0;
      q0.delete();
      q1.delete();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk_i);
      chk_clear("midrst");
      @(posedge clk_i);
      #1;
      // First tie after reset goes to port 0
      cyc(1, 4'd0, 32'd1, 32'd1, 32'd2, 1, 4'd0, 32'd2, 32'd2, 32'd4, 1, 1, 1, 1);
      idle(1, 1, 0, 0);
      idle(1, 1, 0, 0);

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters: port 0 is the execute stage, port 1 is the address/CSR helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with optional fixed priority. The block drives the ALU operand/opcode inputs and captures the ALU result into a per-requester response register.
- Sits between the issue logic and the ALU instance in the core.

Parameters:
- XLEN, 32, operand/result width.
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = requester 0 always wins ties.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_opcode_i  input  4  ALU opcode (ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9)
- req0_op1_i  input  XLEN  operand 1
- req0_op2_i  input  XLEN  operand 2
- rsp0_valid_o  output  1  result for requester 0 available
- rsp0_ready_i  input  1  requester 0 consumes result
- rsp0_data_o  output  XLEN  result for requester 0
- req1_valid_i, req1_ready_o, req1_opcode_i, req1_op1_i, req1_op2_i, rsp1_valid_o, rsp1_ready_i, rsp1_data_o: identical for requester 1
- alu_opcode_o  output  4  to shared ALU
- alu_op1_o  output  XLEN  to shared ALU
- alu_op2_o  output  XLEN  to shared ALU
- alu_res_i  input  XLEN  combinational result from shared ALU

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - rsp0_valid_o = rsp1_valid_o = 0
  - rsp0_data_o = rsp1_data_o = 0
  - last-grant pointer = 1, so requester 0 wins the first tie
- Response slots:
  - Each requester k has a slot, state EMPTY or FULL; FULL corresponds to rspk_valid_o = 1.
  - slot_free_k = EMPTY, or (FULL and rspk_ready_i) in the same cycle.
- Eligibility and grant:
  - eligible_k = reqk_valid_i & slot_free_k.
  - At most one grant per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible with ROUND_ROBIN=1, the requester not equal to the last-grant pointer wins.
  - If both are eligible with ROUND_ROBIN=0, requester 0 wins.
- Ready outputs:
  - reqk_ready_o = 1 only for the granted requester. It is combinational from valid inputs, rsp ready inputs and state.
  - reqk_ready_o must not depend on reqk_ready_o of the other port through a loop.
- ALU drive:
  - When a grant exists, alu_opcode_o/alu_op1_o/alu_op2_o equal the granted requester's inputs unchanged.
  - With no grant, all three are 0.
- Accept (posedge with grant to k):
  - rspk_data_o <= alu_res_i; rspk_valid_o <= 1.
  - Pointer <= k, updated only on accept.
- Drain: FULL slot with rspk_ready_i and no new accept -> rspk_valid_o <= 0. rspk_data_o holds its last value.
- Simultaneous drain and accept on the same port: the slot stays FULL with the new data. This gives back-to-back throughput of one op per cycle on a single port.
- Stability while FULL: rspk_data_o and rspk_valid_o are stable until the consuming handshake.
- Latency: request accepted at edge N; result visible on rspk_data_o with rspk_valid_o = 1 after edge N, i.e. one cycle.
- Opcodes 10..15 are passed through unchanged. The ALU returns 0, and the block returns 0 with a normal handshake.
- Request stability: the requester must hold its request inputs stable while valid and not ready. The block does not latch request data before accept.
- Reset mid-operation: any FULL slot is discarded (valid = 0, data = 0) and the pointer returns to 1. An in-flight grant in the reset cycle does not write the slot.
- Starvation bound with ROUND_ROBIN=1: a continuously eligible requester is granted within 2 cycles.

Test Plan:
- Reset, then req0 ADD op1=5 op2=7 with rsp0_ready_i=1 -> req0_ready_o=1 in the same cycle; alu_op1_o=5; next cycle rsp0_valid_o=1, rsp0_data_o=12.
- Both valid every cycle, rsp ready held 1, ROUND_ROBIN=1: req0 SUB 10-3, req1 SLTU 0xFFFFFFFF<1 -> grants alternate 0,1,0,1; rsp0_data_o=7, rsp1_data_o=0.
- Same stimulus with ROUND_ROBIN=0 -> req0 granted every cycle, req1_ready_o stays 0; with req0 deasserted, req1 granted.
- rsp1_ready_i=0 with rsp1 FULL holding 0x80000000 (SRA 0x80000000 by 0 result), req1 valid again -> req1_ready_o=0 and data held; raise rsp1_ready_i -> drain and new accept in the same cycle, slot stays FULL with the new result.
- Opcode 12 on req0 -> accepted, rsp0_data_o=0, rsp0_valid_o=1.
- Assert rst_i while both slots are FULL and a grant is active -> next cycle both rsp valid outputs are 0 and data is 0; the first tie after reset is granted to requester 0.
